// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem handshake,
// one-entry holding buffer and the IF/ID instruction register.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'hF000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_write,
    input  logic        ir_write,
    input  logic        flush_if,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic        i_readM,
    output logic [15:0] i_address,
    input  logic [15:0] i_data,
    input  logic        i_ready,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic [15:0] ir_next_pc,
    output logic        ir_valid
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        readm_q, readm_d;
    logic [15:0] addr_q, addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] buf_inst_q, buf_inst_d;
    logic [15:0] buf_pc_q, buf_pc_d;
    logic        squash_q, squash_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic [15:0] ir_next_pc_q, ir_next_pc_d;
    logic        ir_valid_q, ir_valid_d;

    logic resp;
    logic resp_good;
    logic issue;

    always_comb begin
        resp      = (state_q == BUSY) && i_ready;
        resp_good = resp && !squash_q && !redirect_valid;
        issue     = (state_q == IDLE) && !buf_valid_q && pc_write && !redirect_valid;

        state_d      = state_q;
        pc_d         = pc_q;
        readm_d      = readm_q;
        addr_d       = addr_q;
        buf_valid_d  = buf_valid_q;
        buf_inst_d   = buf_inst_q;
        buf_pc_d     = buf_pc_q;
        squash_d     = squash_q;
        ir_d         = ir_q;
        ir_pc_d      = ir_pc_q;
        ir_next_pc_d = ir_next_pc_q;
        ir_valid_d   = ir_valid_q;

        if (issue) begin
            state_d = BUSY;
            readm_d = 1'b1;
            addr_d  = pc_q;
            pc_d    = pc_q + 16'd1;
        end else if (resp) begin
            state_d = IDLE;
            readm_d = 1'b0;
        end

        if (redirect_valid)
            pc_d = redirect_target;

        // A redirect with the request still outstanding must kill its late reply.
        if (resp)
            squash_d = 1'b0;
        else if (redirect_valid && state_q == BUSY)
            squash_d = 1'b1;

        if (redirect_valid || flush_if) begin
            ir_d        = NOP_INST;
            ir_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
        end else if (!ir_write) begin
            if (resp_good) begin
                buf_valid_d = 1'b1;
                buf_inst_d  = i_data;
                buf_pc_d    = addr_q;
            end
        end else if (buf_valid_q) begin
            ir_d         = buf_inst_q;
            ir_pc_d      = buf_pc_q;
            ir_next_pc_d = buf_pc_q + 16'd1;
            ir_valid_d   = 1'b1;
            buf_valid_d  = 1'b0;
            if (resp_good) begin
                buf_valid_d = 1'b1;
                buf_inst_d  = i_data;
                buf_pc_d    = addr_q;
            end
        end else if (resp_good) begin
            ir_d         = i_data;
            ir_pc_d      = addr_q;
            ir_next_pc_d = addr_q + 16'd1;
            ir_valid_d   = 1'b1;
        end else begin
            ir_d       = NOP_INST;
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            readm_q      <= 1'b0;
            addr_q       <= RESET_PC;
            buf_valid_q  <= 1'b0;
            buf_inst_q   <= '0;
            buf_pc_q     <= '0;
            squash_q     <= 1'b0;
            ir_q         <= NOP_INST;
            ir_pc_q      <= 16'h0000;
            ir_next_pc_q <= 16'h0001;
            ir_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            readm_q      <= readm_d;
            addr_q       <= addr_d;
            buf_valid_q  <= buf_valid_d;
            buf_inst_q   <= buf_inst_d;
            buf_pc_q     <= buf_pc_d;
            squash_q     <= squash_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            ir_next_pc_q <= ir_next_pc_d;
            ir_valid_q   <= ir_valid_d;
        end
    end

    assign i_readM    = readm_q;
    assign i_address  = addr_q;
    assign ir         = ir_q;
    assign ir_pc      = ir_pc_q;
    assign ir_next_pc = ir_next_pc_q;
    assign ir_valid   = ir_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming fetch, stall buffering, redirect
// squash, flush, PC wrap and reset while a request is outstanding.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        pc_write, ir_write, flush_if, redirect_valid;
    logic [15:0] redirect_target;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic [15:0] ir, ir_pc, ir_next_pc;
    logic        ir_valid;

    logic        reset5_n;
    logic        i_readM5, i_ready5, ir_valid5;
    logic [15:0] i_address5, i_data5, ir5, ir_pc5, ir_next_pc5;

    int          vectors = 0;
    int          miscompares = 0;

    int          mem_lat = 1;
    int          wait_cnt = 0;
    bit          mem_manual = 1'b0;
    logic        man_ready = 1'b0;
    logic [15:0] man_data = 16'h0000;
    bit          ovr_en = 1'b1;
    logic [15:0] ovr_addr = 16'h0005;
    logic [15:0] ovr_data = 16'h1234;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .pc_write(pc_write), .ir_write(ir_write),
        .flush_if(flush_if), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .i_readM(i_readM),
        .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
        .ir(ir), .ir_pc(ir_pc), .ir_next_pc(ir_next_pc), .ir_valid(ir_valid)
    );

    fetch_stage #(.RESET_PC(16'hFFFF), .NOP_INST(16'hF000)) dut5 (
        .clk(clk), .reset_n(reset5_n), .pc_write(1'b1), .ir_write(1'b1),
        .flush_if(1'b0), .redirect_valid(1'b0), .redirect_target(16'h0000),
        .i_readM(i_readM5), .i_address(i_address5), .i_data(i_data5),
        .i_ready(i_ready5), .ir(ir5), .ir_pc(ir_pc5), .ir_next_pc(ir_next_pc5),
        .ir_valid(ir_valid5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers at the falling edge: mem_lat cycles after i_readM is seen.
    initial begin
        i_ready = 1'b0;
        i_data  = 16'h0000;
    end
    always @(negedge clk) begin
        if (mem_manual) begin
            i_ready = man_ready;
            i_data  = man_data;
        end else if (i_readM) begin
            if (wait_cnt + 1 >= mem_lat) begin
                i_ready  = 1'b1;
                i_data   = (ovr_en && i_address == ovr_addr) ? ovr_data : (i_address ^ 16'hA5A5);
                wait_cnt = 0;
            end else begin
                i_ready  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            i_ready  = 1'b0;
            wait_cnt = 0;
        end
    end

    initial begin
        i_ready5 = 1'b0;
        i_data5  = 16'h0000;
    end
    always @(negedge clk) begin
        i_ready5 = i_readM5;
        i_data5  = i_address5 ^ 16'hA5A5;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ir(input string tag, input logic [15:0] e_ir, input logic [15:0] e_pc,
                          input logic [15:0] e_npc, input logic e_valid);
        chk({tag, ".ir"}, ir, e_ir);
        chk({tag, ".ir_pc"}, ir_pc, e_pc);
        chk({tag, ".ir_next_pc"}, ir_next_pc, e_npc);
        chk({tag, ".ir_valid"}, {15'd0, ir_valid}, {15'd0, e_valid});
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".ir"}, ir, 16'hF000);
        chk({tag, ".ir_valid"}, {15'd0, ir_valid}, 16'd0);
    endtask

    task automatic chk_req(input string tag, input logic e_rd, input logic [15:0] e_addr);
        chk({tag, ".i_readM"}, {15'd0, i_readM}, {15'd0, e_rd});
        if (e_rd) chk({tag, ".i_address"}, i_address, e_addr);
    endtask

    initial begin
        reset_n = 1'b0; reset5_n = 1'b0;
        pc_write = 1'b1; ir_write = 1'b1; flush_if = 1'b0;
        redirect_valid = 1'b0; redirect_target = 16'h0000;
        tick; tick;
        chk("rst.i_readM", {15'd0, i_readM}, 16'd0);
        chk("rst.i_address", i_address, 16'h0000);
        chk_ir("rst", 16'hF000, 16'h0000, 16'h0001, 1'b0);
        reset_n = 1'b1;

        // streaming fetch, 1-cycle memory
        tick; chk_req("t1.e1", 1'b1, 16'h0000); chk_bubble("t1.e1");
        tick; chk_req("t1.e2", 1'b0, 16'h0000); chk_ir("t1.e2", 16'hA5A5, 16'h0000, 16'h0001, 1'b1);
        tick; chk_req("t1.e3", 1'b1, 16'h0001); chk_bubble("t1.e3");
        tick; chk_ir("t1.e4", 16'hA5A4, 16'h0001, 16'h0002, 1'b1);
        tick; chk_req("t1.e5", 1'b1, 16'h0002); chk_bubble("t1.e5");
        tick; chk_ir("t1.e6", 16'hA5A7, 16'h0002, 16'h0003, 1'b1);
        tick; chk_req("t1.e7", 1'b1, 16'h0003);
        tick; chk_ir("t1.e8", 16'hA5A6, 16'h0003, 16'h0004, 1'b1);
        tick; chk_req("t1.e9", 1'b1, 16'h0004);
        tick; chk_ir("t1.e10", 16'hA5A1, 16'h0004, 16'h0005, 1'b1);

        // stall while the fetch of 5 completes: word must be held in the buffer
        tick; chk_req("t2.e11", 1'b1, 16'h0005);
        pc_write = 1'b0; ir_write = 1'b0;
        tick; chk_req("t2.e12", 1'b0, 16'h0000); chk_bubble("t2.e12");
        tick; chk_req("t2.e13", 1'b0, 16'h0000); chk_bubble("t2.e13");
        pc_write = 1'b1; ir_write = 1'b1;
        tick; chk_req("t2.e14", 1'b0, 16'h0000); chk_ir("t2.e14", 16'h1234, 16'h0005, 16'h0006, 1'b1);
        tick; chk_req("t2.e15", 1'b1, 16'h0006); chk_bubble("t2.e15");
        tick; chk_ir("t2.e16", 16'hA5A3, 16'h0006, 16'h0007, 1'b1);

        // flush in the same cycle as the reply for 7
        tick; chk_req("t4.e17", 1'b1, 16'h0007);
        flush_if = 1'b1;
        tick; chk_req("t4.e18", 1'b0, 16'h0000); chk_bubble("t4.e18");
        flush_if = 1'b0;
        tick; chk_req("t4.e19", 1'b1, 16'h0008); chk_bubble("t4.e19");
        tick; chk_ir("t4.e20", 16'hA5AD, 16'h0008, 16'h0009, 1'b1);

        // redirect while a 3-cycle request to 0x10 is outstanding
        redirect_valid = 1'b1; redirect_target = 16'h0010;
        tick; chk_req("t3.e21", 1'b0, 16'h0000); chk_bubble("t3.e21");
        redirect_valid = 1'b0; mem_lat = 3;
        tick; chk_req("t3.e22", 1'b1, 16'h0010);
        tick; chk_req("t3.e23", 1'b1, 16'h0010);
        redirect_valid = 1'b1; redirect_target = 16'h0040;
        tick; chk_req("t3.e24", 1'b1, 16'h0010); chk_bubble("t3.e24");
        redirect_valid = 1'b0;
        tick; chk_req("t3.e25", 1'b0, 16'h0000); chk_bubble("t3.e25");
        mem_lat = 1;
        tick; chk_req("t3.e26", 1'b1, 16'h0040); chk_bubble("t3.e26");
        tick; chk_ir("t3.e27", 16'hA5E5, 16'h0040, 16'h0041, 1'b1);

        // reset while BUSY, with i_ready pulsing during and just after reset
        tick; chk_req("t6.e28", 1'b1, 16'h0041);
        mem_manual = 1'b1; man_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t6.async.i_readM", {15'd0, i_readM}, 16'd0);
        chk("t6.async.i_address", i_address, 16'h0000);
        chk_ir("t6.async", 16'hF000, 16'h0000, 16'h0001, 1'b0);
        tick;
        man_ready = 1'b1; man_data = 16'hDEAD;
        tick;
        chk("t6.inrst.i_readM", {15'd0, i_readM}, 16'd0);
        reset_n = 1'b1;
        tick; chk_req("t6.r1", 1'b1, 16'h0000); chk_bubble("t6.r1");
        mem_manual = 1'b0; man_ready = 1'b0;
        tick; chk_ir("t6.r2", 16'hA5A5, 16'h0000, 16'h0001, 1'b1);

        // RESET_PC = FFFF wraps to 0000
        reset5_n = 1'b1;
        tick;
        chk("t5.r1.i_readM", {15'd0, i_readM5}, 16'd1);
        chk("t5.r1.i_address", i_address5, 16'hFFFF);
        tick;
        chk("t5.r2.ir", ir5, 16'h5A5A);
        chk("t5.r2.ir_pc", ir_pc5, 16'hFFFF);
        chk("t5.r2.ir_next_pc", ir_next_pc5, 16'h0000);
        chk("t5.r2.ir_valid", {15'd0, ir_valid5}, 16'd1);
        tick;
        chk("t5.r3.i_readM", {15'd0, i_readM5}, 16'd1);
        chk("t5.r3.i_address", i_address5, 16'h0000);
        tick;
        chk("t5.r4.ir", ir5, 16'hA5A5);
        chk("t5.r4.ir_pc", ir_pc5, 16'h0000);
        chk("t5.r4.ir_next_pc", ir_next_pc5, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
